// File: rtl/ysyx_201979054_div_pkg.sv
// Shared encodings and sizing constants for the iterative RV64M divider.
package ysyx_201979054_div_pkg;

  typedef enum logic [2:0] {
    DIV   = 3'b000,
    DIVU  = 3'b001,
    REM   = 3'b010,
    REMU  = 3'b011,
    DIVW  = 3'b100,
    DIVUW = 3'b101,
    REMW  = 3'b110,
    REMUW = 3'b111
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  localparam int N_DWORD   = 64;
  localparam int N_WORD    = 32;
  localparam int CNT_WIDTH = 7;

endpackage

// File: rtl/ysyx_201979054_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract the divisor.
module ysyx_201979054_div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] trial;

  always_comb begin
    trial = {rem_in, quo_in[WIDTH-1]} - {2'b00, divisor};
    if (trial[WIDTH+1]) begin
      rem_out = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = trial[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ysyx_201979054_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM (incl. W variants).
// Optional DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |a|<|b| bypass the iteration.
module ysyx_201979054_div_unit
  import ysyx_201979054_div_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [OP_WIDTH-1:0]   i_div_op,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int HI_WIDTH = DATA_WIDTH - WORD_WIDTH;

  state_t                  state;
  logic                    word_q;
  logic                    rem_sel_q;
  logic                    neg_q;
  logic                    neg_r;
  logic                    div_zero_q;
  logic [DATA_WIDTH-1:0]   divisor_q;
  logic [DATA_WIDTH:0]     rem_q;
  logic [DATA_WIDTH-1:0]   quo_q;
  logic [CNT_WIDTH-1:0]    cnt_q;

  logic                    op_word;
  logic                    op_rem;
  logic                    op_uns;
  logic [DATA_WIDTH-1:0]   a_ext;
  logic [DATA_WIDTH-1:0]   b_ext;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_WIDTH-1:0]   a_mag;
  logic [DATA_WIDTH-1:0]   b_mag;
  logic                    div_zero;
  logic                    accept;

  logic [DATA_WIDTH:0]     step_rem;
  logic [DATA_WIDTH-1:0]   step_quo;

  logic [DATA_WIDTH-1:0]   q_fix;
  logic [DATA_WIDTH-1:0]   r_fix;
  logic [DATA_WIDTH-1:0]   sel;
  logic [DATA_WIDTH-1:0]   fix_result;

  assign op_word = i_div_op[2];
  assign op_rem  = i_div_op[1];
  assign op_uns  = i_div_op[0];
  assign accept  = i_valid && o_ready && !i_flush;

  always_comb begin
    if (op_word) begin
      a_ext = op_uns ? {{HI_WIDTH{1'b0}}, i_src_1[WORD_WIDTH-1:0]}
                     : {{HI_WIDTH{i_src_1[WORD_WIDTH-1]}}, i_src_1[WORD_WIDTH-1:0]};
      b_ext = op_uns ? {{HI_WIDTH{1'b0}}, i_src_2[WORD_WIDTH-1:0]}
                     : {{HI_WIDTH{i_src_2[WORD_WIDTH-1]}}, i_src_2[WORD_WIDTH-1:0]};
    end else begin
      a_ext = i_src_1;
      b_ext = i_src_2;
    end
    a_neg    = !op_uns && a_ext[DATA_WIDTH-1];
    b_neg    = !op_uns && b_ext[DATA_WIDTH-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_mag == '0);
  end

`ifdef DIV_EARLY_OUT_EN
  logic                  ovf;
  logic                  early;
  logic [DATA_WIDTH-1:0] min_val;

  always_comb begin
    min_val = op_word ? {{(HI_WIDTH + 1){1'b1}}, {(WORD_WIDTH - 1){1'b0}}}
                      : {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    ovf     = !op_uns && (b_ext == '1) && (a_ext == min_val);
    early   = div_zero || ovf || (a_mag < b_mag);
  end
`endif

  ysyx_201979054_div_step #(
    .WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(divisor_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  // W results live in the low word; negation over the full width keeps the low word correct.
  always_comb begin
    q_fix      = div_zero_q ? '1 : (neg_q ? -quo_q : quo_q);
    r_fix      = neg_r ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
    sel        = rem_sel_q ? r_fix : q_fix;
    fix_result = word_q ? {{HI_WIDTH{sel[WORD_WIDTH-1]}}, sel[WORD_WIDTH-1:0]} : sel;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_result   <= '0;
      word_q     <= 1'b0;
      rem_sel_q  <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero_q <= 1'b0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            o_ready    <= 1'b0;
            word_q     <= op_word;
            rem_sel_q  <= op_rem;
            neg_q      <= a_neg ^ b_neg;
            neg_r      <= a_neg;
            div_zero_q <= div_zero;
            divisor_q  <= b_mag;
            cnt_q      <= op_word ? CNT_WIDTH'(N_WORD - 1) : CNT_WIDTH'(N_DWORD - 1);
`ifdef DIV_EARLY_OUT_EN
            if (early) begin
              state <= FIXUP;
              quo_q <= ovf ? a_mag : '0;
              rem_q <= ovf ? '0 : {1'b0, a_mag};
            end else
`endif
            begin
              state <= CALC;
              // W dividends sit in the upper word so they shift out first.
              quo_q <= op_word ? (a_mag << WORD_WIDTH) : a_mag;
              rem_q <= '0;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            state   <= IDLE;
            o_ready <= 1'b1;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            if (cnt_q == '0) state <= FIXUP;
            else             cnt_q <= cnt_q - 1'b1;
          end
        end
        FIXUP: begin
          if (i_flush) begin
            state   <= IDLE;
            o_ready <= 1'b1;
          end else begin
            o_result <= fix_result;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_flush) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end else if (!o_valid) begin
            // Valid follows the registered result by one edge: N+2 edges total.
            o_valid <= 1'b1;
          end else if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_201979054_div_unit.sv
// Scoreboard bench for ysyx_201979054_div_unit: directed vectors, latency and handshake checks.
module tb_ysyx_201979054_div_unit;
  import ysyx_201979054_div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    div_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    bit          eo;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          lat;
    int          acc;
    int          id;
  } sb_t;

  logic        clk;
  logic        arstn;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_div_op;
  logic [63:0] i_src_1;
  logic [63:0] i_src_2;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_result;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;
  sb_t  sb[$];
  vec_t vecs[$];

  ysyx_201979054_div_unit #(
    .DATA_WIDTH(64),
    .WORD_WIDTH(32),
    .OP_WIDTH  (3)
  ) dut (
    .clk     (clk),
    .arstn   (arstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_div_op(i_div_op),
    .i_src_1 (i_src_1),
    .i_src_2 (i_src_2),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input div_op_t op, input bit eo);
    if (EARLY && eo) return 2;
    return op[2] ? 34 : 66;
  endfunction

  // Monitor: latency on the first cycle of o_valid, result on the handshake.
  always @(negedge clk) begin
    if (arstn && o_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got o_valid=1 expected no pending op (result 0x%016h)", o_result);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check($sformatf("latency[%0d]", sb[0].id), 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        end
        if (i_ready) begin
          check($sformatf("result[%0d]", sb[0].id), o_result, sb[0].exp);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input vec_t v, input bit push, input int id);
    int t;
    t = 0;
    @(negedge clk);
    while (!o_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout[%0d]: got o_ready=0 expected 1", id);
    end
    i_div_op = v.op;
    i_src_1  = v.a;
    i_src_2  = v.b;
    i_valid  = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    if (push) sb.push_back('{exp: v.exp, lat: exp_lat(v.op, v.eo), acc: cyc, id: id});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t;
    bit   any_valid;
    vec_t v;

    arstn    = 1'b0;
    i_valid  = 1'b0;
    i_flush  = 1'b0;
    i_ready  = 1'b1;
    i_div_op = '0;
    i_src_1  = '0;
    i_src_2  = '0;

    vecs.push_back('{DIVU,  64'd100, 64'd7, 64'd14, 1'b0});
    vecs.push_back('{REMU,  64'd100, 64'd7, 64'd2, 1'b0});
    vecs.push_back('{DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0});
    vecs.push_back('{REM,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{REM,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0});
    vecs.push_back('{DIVW,  64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1});
    vecs.push_back('{REMW,  64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1});
    vecs.push_back('{DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{DIVU,  64'h55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{REMU,  64'h1234, 64'd0, 64'h1234, 1'b1});
    vecs.push_back('{DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1});
    vecs.push_back('{DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1});
    vecs.push_back('{REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1});
    vecs.push_back('{DIV,   64'd5, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 1'b1});
    vecs.push_back('{REM,   64'hFFFF_FFFF_FFFF_FFFB, 64'd100, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1});
    vecs.push_back('{DIVW,  64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0});
    vecs.push_back('{REMUW, 64'h0000_0001_0000_0007, 64'hABCD_0000_0000_0002, 64'd1, 1'b0});
    vecs.push_back('{DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 1'b0});

    #12;
    check("reset_o_ready", 64'(o_ready), 64'd1);
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_result", o_result, 64'd0);
    @(negedge clk);
    arstn = 1'b1;

    foreach (vecs[i]) issue(vecs[i], 1'b1, i);
    drain();

    // Request together with flush in IDLE must not be accepted.
    @(negedge clk);
    i_div_op = DIVU;
    i_src_1  = 64'd1;
    i_src_2  = 64'd1;
    i_valid  = 1'b1;
    i_flush  = 1'b1;
    @(posedge clk);
    #1;
    check("valid_with_flush_not_accepted", 64'(o_ready), 64'd1);
    i_valid = 1'b0;
    i_flush = 1'b0;

    // Consumer back-pressure in DONE.
    i_ready = 1'b0;
    v = '{DIVU, 64'd100, 64'd7, 64'd14, 1'b0};
    issue(v, 1'b1, 100);
    t = 0;
    while (!o_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("hold_valid_reached", 64'(o_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_o_valid", 64'(o_valid), 64'd1);
      check("hold_o_result", o_result, 64'd14);
      check("hold_o_ready", 64'(o_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    drain();
    @(posedge clk);
    #1;
    check("ready_after_handshake", 64'(o_ready), 64'd1);

    // Flush in the middle of CALC.
    v = '{DIVU, 64'd123, 64'd5, 64'd24, 1'b0};
    issue(v, 1'b0, 101);
    repeat (19) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check("flush_o_ready", 64'(o_ready), 64'd1);
    check("flush_o_valid", 64'(o_valid), 64'd0);
    any_valid = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (o_valid) any_valid = 1'b1;
    end
    check("flush_no_result", 64'(any_valid), 64'd0);
    v = '{DIVU, 64'd9, 64'd3, 64'd3, 1'b0};
    issue(v, 1'b1, 102);
    drain();

    // Asynchronous reset mid-CALC.
    v = '{DIVU, 64'd1000, 64'd3, 64'd333, 1'b0};
    issue(v, 1'b0, 103);
    repeat (10) @(posedge clk);
    #2;
    arstn = 1'b0;
    #1;
    check("async_rst_o_ready", 64'(o_ready), 64'd1);
    check("async_rst_o_valid", 64'(o_valid), 64'd0);
    check("async_rst_o_result", o_result, 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    v = '{REMU, 64'd1000, 64'd3, 64'd1, 1'b0};
    issue(v, 1'b1, 104);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
